pc_trace_monitor: RTL and testbench
===================================

Name: pc_trace_monitor

Overview:
Synthesizable successor to the datapath tester's cycle-count/stop logic. Samples the DataPath fetch signals (pcQ, pcD, instruction, regWriteEnable) every clock into a parametrised circular trace buffer. Counts cycles and halts on a programmable cycle limit or PC breakpoint. While halted, the trace is read out oldest-first over a simple request/valid handshake. Sits beside DataPath at top level.

Parameters:
ADDR_W, 32, width of pcQ/pcD/bpAddr/rdPc
INSTR_W, 32, width of instruction/rdInstr
DEPTH, 16, trace entries; power of 2, >= 2
CYCLE_W, 32, width of cycle counter and cycleLimit

Ports:
clock  in  1  rising-edge clock; the only clock
resetN  in  1  asynchronous, active-low reset
pcQ  in  ADDR_W  current PC
pcD  in  ADDR_W  next PC
instruction  in  INSTR_W  fetched instruction
regWriteEnable  in  1  register-file write enable
traceEnable  in  1  capture enable while running
cycleLimit  in  CYCLE_W  halt when cycleCount reaches this value; 0 = no limit
bpEnable  in  1  breakpoint enable
bpAddr  in  ADDR_W  breakpoint PC
resume  in  1  HALTED -> RUN
clearTrace  in  1  empty buffer, clear overflow
rdReq  in  1  pop oldest entry (HALTED only)
halted  out  1  1 in HALTED
haltCause  out  2  [0]=breakpoint, [1]=cycle limit
cycleCount  out  CYCLE_W  cycles spent in RUN
count  out  log2(DEPTH)+1  valid entries
overflow  out  1  sticky: an entry was overwritten
rdValid  out  1  rd* outputs valid this cycle
rdPc  out  ADDR_W  popped pcQ
rdPcD  out  ADDR_W  popped pcD
rdInstr  out  INSTR_W  popped instruction
rdWe  out  1  popped regWriteEnable

Behaviour:
- Reset (async, immediate on resetN low): state RUN; halted=0, haltCause=0, cycleCount=0, count=0, overflow=0, rdValid=0, rdPc/rdPcD/rdInstr/rdWe=0; head/tail pointers=0. Reset mid-readout or mid-capture discards everything.
- States: RUN, HALTED. Nothing else.
- RUN, each edge: cycleCount += 1 (wraps modulo 2^CYCLE_W). If traceEnable, write {pcQ,pcD,instruction,regWriteEnable} at the tail. If count==DEPTH, overwrite the oldest entry (head advances), count stays DEPTH, overflow<=1. Otherwise count += 1.
- Halt check on the same edge, using the current inputs and the post-increment count:
  - bpHit = bpEnable && pcQ==bpAddr.
  - limHit = cycleLimit!=0 && cycleCount+1==cycleLimit.
  - Either hit: state<=HALTED, halted<=1, haltCause<={limHit,bpHit}. Both bits set if both hit.
  - The hitting cycle is still counted and captured.
- HALTED: no capture, cycleCount frozen, inputs pcQ etc. ignored.
- Readout (HALTED only): rdReq with count>0 -> next edge rdValid=1 and rd* = head entry; head advances; count -= 1. rdReq with count==0, or in RUN: rdValid=0 next edge, rd* hold, no state change. rdValid is a 1-cycle pulse per pop; back-to-back pops every cycle allowed.
- resume in HALTED: next edge state RUN, halted=0, haltCause=0. Buffer, cycleCount and overflow are kept. resume in RUN is ignored. resume+rdReq in the same cycle: the pop completes, then RUN.
- If cycleCount already equals or exceeds cycleLimit at resume, the limit does not re-fire until the count wraps to it again.
- clearTrace (any state): next edge count=0, head=tail, overflow=0. Clear wins over a simultaneous capture (entry discarded) and over a simultaneous rdReq (rdValid=0). cycleCount is unaffected.
- Pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
1. Reset, traceEnable=1, cycleLimit=20, PC stepping 0x00400000 +4 per cycle -> halted=1 after edge 20, haltCause=2'b10, cycleCount=20, count=16, overflow=1. 16 pops return pcQ 0x00400010..0x0040004C in order; rdValid pulses 16 times; count=0.
2. bpEnable=1, bpAddr=0x00400014, cycleLimit=0 -> halt after 6th edge, haltCause=2'b01, count=6, last popped rdPc=0x00400014.
3. cycleLimit=6 with bpAddr=0x00400014 (both fire on same edge) -> haltCause=2'b11.
4. While halted with count=3, rdReq held 5 cycles -> exactly 3 rdValid pulses, then count=0 and rdValid stays 0. Then resume -> halted=0 next edge, cycleCount resumes counting from its frozen value.
5. In RUN with count=5, assert clearTrace and traceEnable together -> count=0 and overflow=0 next edge; the following capture gives count=1.
6. Drop resetN asynchronously mid-readout (between edges) -> all outputs 0 immediately; after release, state RUN, count=0.

Source files
------------

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: captures the DataPath fetch stream into a circular trace
// buffer, counts run cycles, halts on a cycle limit or PC breakpoint, and lets
// the trace be drained oldest-first while halted.
module pc_trace_monitor #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [ADDR_W-1:0]  pcQ,
  input  logic [ADDR_W-1:0]  pcD,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               regWriteEnable,
  input  logic               traceEnable,
  input  logic [CYCLE_W-1:0] cycleLimit,
  input  logic               bpEnable,
  input  logic [ADDR_W-1:0]  bpAddr,
  input  logic               resume,
  input  logic               clearTrace,
  input  logic               rdReq,
  output logic               halted,
  output logic [1:0]         haltCause,
  output logic [CYCLE_W-1:0] cycleCount,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic               rdValid,
  output logic [ADDR_W-1:0]  rdPc,
  output logic [ADDR_W-1:0]  rdPcD,
  output logic [INSTR_W-1:0] rdInstr,
  output logic               rdWe
);

  localparam int ENT_W = 2 * ADDR_W + INSTR_W + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic               ovf_q, ovf_d;
  logic               rdv_q, rdv_d;
  logic [ENT_W-1:0]   rd_q, rd_d;
  logic               wr_en;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic bp_hit, lim_hit, full;

  // Halt conditions look at the count this edge will produce, so a limit of N
  // halts with cycleCount == N.
  assign bp_hit  = bpEnable && (pcQ == bpAddr);
  assign lim_hit = (cycleLimit != '0) && ((cyc_q + CYCLE_W'(1)) == cycleLimit);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Next-state: capture/count while running, pop/resume while halted; clear wins.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;
    rdv_d   = 1'b0;
    rd_d    = rd_q;
    wr_en   = 1'b0;
    case (state_q)
      RUN: begin
        cyc_d = cyc_q + CYCLE_W'(1);
        if (clearTrace) begin
          cnt_d  = '0;
          head_d = tail_q;
          ovf_d  = 1'b0;
        end else if (traceEnable) begin
          wr_en  = 1'b1;
          tail_d = tail_q + PTR_W'(1);
          if (full) begin
            head_d = head_q + PTR_W'(1);
            ovf_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (bp_hit || lim_hit) begin
          state_d = HALTED;
          cause_d = {lim_hit, bp_hit};
        end
      end
      HALTED: begin
        if (clearTrace) begin
          cnt_d  = '0;
          head_d = tail_q;
          ovf_d  = 1'b0;
        end else if (rdReq && (cnt_q != '0)) begin
          rdv_d  = 1'b1;
          rd_d   = mem_q[head_q];
          head_d = head_q + PTR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
        end
        if (resume) begin
          state_d = RUN;
          cause_d = 2'b00;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control and readout registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= RUN;
      cause_q <= 2'b00;
      cyc_q   <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ovf_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
      rdv_q   <= rdv_d;
      rd_q    <= rd_d;
    end
  end

  // Trace storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[tail_q] <= {pcQ, pcD, instruction, regWriteEnable};
  end

  assign halted     = (state_q == HALTED);
  assign haltCause  = cause_q;
  assign cycleCount = cyc_q;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign rdValid    = rdv_q;
  assign {rdPc, rdPcD, rdInstr, rdWe} = rd_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_pc_trace_monitor;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clock = 1'b0, resetN = 1'b0;
  logic [31:0] pcQ = '0, pcD = '0, instruction = '0, cycleLimit = '0, bpAddr = '0;
  logic        regWriteEnable = 1'b0, traceEnable = 1'b0, bpEnable = 1'b0;
  logic        resume = 1'b0, clearTrace = 1'b0, rdReq = 1'b0;
  logic        halted, overflow, rdValid, rdWe;
  logic [1:0]  haltCause;
  logic [31:0] cycleCount, rdPc, rdPcD, rdInstr;
  logic [4:0]  count;

  int n_vec = 0, n_err = 0;

  pc_trace_monitor #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .CYCLE_W(32)) dut (
    .clock(clock), .resetN(resetN), .pcQ(pcQ), .pcD(pcD), .instruction(instruction),
    .regWriteEnable(regWriteEnable), .traceEnable(traceEnable), .cycleLimit(cycleLimit),
    .bpEnable(bpEnable), .bpAddr(bpAddr), .resume(resume), .clearTrace(clearTrace),
    .rdReq(rdReq), .halted(halted), .haltCause(haltCause), .cycleCount(cycleCount),
    .count(count), .overflow(overflow), .rdValid(rdValid), .rdPc(rdPc), .rdPcD(rdPcD),
    .rdInstr(rdInstr), .rdWe(rdWe)
  );

  always #5 clock = ~clock;

  // Reference model: the trace is a plain queue, halting is a flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcd;
    logic [31:0] ins;
    logic        we;
  } ent_t;

  ent_t        m_q[$];
  bit          m_halt;
  logic [1:0]  m_cause;
  logic [31:0] m_cyc;
  bit          m_ovf, m_rdv;
  ent_t        m_rd;

  task automatic model_reset();
    m_q.delete(); m_halt = 0; m_cause = 2'b00; m_cyc = '0;
    m_ovf = 0; m_rdv = 0; m_rd = '0;
  endtask

  task automatic model_step();
    bit bp, lim;
    m_rdv = 0;
    if (!m_halt) begin
      m_cyc = m_cyc + 32'd1;
      if (clearTrace) begin
        m_q.delete(); m_ovf = 0;
      end else if (traceEnable) begin
        m_q.push_back('{pcQ, pcD, instruction, regWriteEnable});
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front()); m_ovf = 1;
        end
      end
      bp  = bpEnable && (pcQ == bpAddr);
      lim = (cycleLimit != 0) && (m_cyc == cycleLimit);
      if (bp || lim) begin
        m_halt = 1; m_cause = {lim, bp};
      end
    end else begin
      if (clearTrace) begin
        m_q.delete(); m_ovf = 0;
      end else if (rdReq && m_q.size() > 0) begin
        m_rd = m_q.pop_front(); m_rdv = 1;
      end
      if (resume) begin
        m_halt = 0; m_cause = 2'b00;
      end
    end
  endtask

  // One clock: model sees the same inputs as the DUT, outputs sampled 1 after the edge.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    traceEnable = 0; bpEnable = 0; cycleLimit = '0; resume = 0;
    clearTrace = 0; rdReq = 0; regWriteEnable = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetN = 0; #2; resetN = 1;
    model_reset();
  endtask

  task automatic set_pc(input logic [31:0] pc);
    pcQ = pc; pcD = pc + 32'd4; instruction = pc ^ 32'hA5A5_0000; regWriteEnable = pc[2];
  endtask

  task automatic test_reset();
    resetN = 0; #1;
    n_vec++;
    if ({halted, haltCause, cycleCount, count, overflow, rdValid, rdPc, rdPcD, rdInstr, rdWe} !== '0) begin
      n_err++; $display("FAIL reset_outputs got halted=%b cause=%b cyc=%0d cnt=%0d ovf=%b rdv=%b exp all 0",
                        halted, haltCause, cycleCount, count, overflow, rdValid);
    end
    @(posedge clock); #1;
    resetN = 1; model_reset();
  endtask

  task automatic test_cycle_limit();
    do_reset();
    traceEnable = 1; cycleLimit = 32'd20;
    for (int i = 0; i < 20; i++) begin
      set_pc(BASE + 32'(4 * i));
      tick();
      if (i == 18) begin
        n_vec++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL lim_early_halt got %b exp 0", halted); end
      end
    end
    traceEnable = 0;
    n_vec++;
    if ({halted, haltCause, cycleCount, count, overflow} !== {1'b1, 2'b10, 32'd20, 5'd16, 1'b1}) begin
      n_err++; $display("FAIL lim_halt got h=%b c=%b cyc=%0d cnt=%0d ovf=%b exp 1 10 20 16 1",
                        halted, haltCause, cycleCount, count, overflow);
    end
    rdReq = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_vec++;
      if (rdValid !== 1'b1 || rdPc !== BASE + 32'h10 + 32'(4 * k)) begin
        n_err++; $display("FAIL lim_pop%0d got v=%b pc=%h exp 1 %h", k, rdValid, rdPc, BASE + 32'h10 + 32'(4 * k));
      end
    end
    rdReq = 0;
    tick();
    n_vec++;
    if (rdValid !== 1'b0 || count !== 5'd0) begin
      n_err++; $display("FAIL lim_drained got v=%b cnt=%0d exp 0 0", rdValid, count);
    end
  endtask

  task automatic run_to_bp(input logic [31:0] lim, input logic [1:0] exp_cause, input string nm);
    logic [31:0] last;
    do_reset();
    traceEnable = 1; bpEnable = 1; bpAddr = BASE + 32'h14; cycleLimit = lim;
    for (int i = 0; i < 6; i++) begin
      set_pc(BASE + 32'(4 * i));
      tick();
    end
    traceEnable = 0; bpEnable = 0;
    n_vec++;
    if ({halted, haltCause, count, cycleCount} !== {1'b1, exp_cause, 5'd6, 32'd6}) begin
      n_err++; $display("FAIL %s_halt got h=%b c=%b cnt=%0d cyc=%0d exp 1 %b 6 6", nm, halted, haltCause, count, cycleCount, exp_cause);
    end
    rdReq = 1; last = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rdValid) last = rdPc;
    end
    rdReq = 0;
    n_vec++;
    if (last !== BASE + 32'h14) begin
      n_err++; $display("FAIL %s_last_pop got %h exp %h", nm, last, BASE + 32'h14);
    end
  endtask

  task automatic test_breakpoint();
    run_to_bp(32'd0, 2'b01, "bp");
  endtask

  task automatic test_both_causes();
    run_to_bp(32'd6, 2'b11, "both");
  endtask

  task automatic test_drain_resume();
    int pulses;
    do_reset();
    traceEnable = 1; bpEnable = 1; bpAddr = BASE + 32'h8;
    for (int i = 0; i < 3; i++) begin
      set_pc(BASE + 32'(4 * i));
      tick();
    end
    traceEnable = 0; bpEnable = 0;
    n_vec++;
    if (halted !== 1'b1 || count !== 5'd3) begin
      n_err++; $display("FAIL drain_setup got h=%b cnt=%0d exp 1 3", halted, count);
    end
    rdReq = 1; pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      pulses += int'(rdValid);
    end
    rdReq = 0;
    n_vec++;
    if (pulses != 3 || count !== 5'd0 || rdValid !== 1'b0) begin
      n_err++; $display("FAIL drain_pulses got p=%0d cnt=%0d v=%b exp 3 0 0", pulses, count, rdValid);
    end
    resume = 1;
    tick();
    resume = 0;
    n_vec++;
    if (halted !== 1'b0 || haltCause !== 2'b00 || cycleCount !== 32'd3) begin
      n_err++; $display("FAIL resume got h=%b c=%b cyc=%0d exp 0 00 3", halted, haltCause, cycleCount);
    end
    tick();
    n_vec++;
    if (cycleCount !== 32'd4) begin
      n_err++; $display("FAIL resume_count got %0d exp 4", cycleCount);
    end
  endtask

  task automatic test_clear();
    do_reset();
    traceEnable = 1;
    for (int i = 0; i < 5; i++) begin
      set_pc(BASE + 32'(4 * i)); tick();
    end
    n_vec++;
    if (count !== 5'd5) begin n_err++; $display("FAIL clr_pre5 got %0d exp 5", count); end
    for (int i = 5; i < 20; i++) begin
      set_pc(BASE + 32'(4 * i)); tick();
    end
    n_vec++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_err++; $display("FAIL clr_pre_ovf got ovf=%b cnt=%0d exp 1 16", overflow, count);
    end
    clearTrace = 1; tick(); clearTrace = 0;
    n_vec++;
    if (count !== 5'd0 || overflow !== 1'b0 || cycleCount !== 32'd21) begin
      n_err++; $display("FAIL clr_clear got cnt=%0d ovf=%b cyc=%0d exp 0 0 21", count, overflow, cycleCount);
    end
    tick();
    n_vec++;
    if (count !== 5'd1) begin n_err++; $display("FAIL clr_next got %0d exp 1", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    traceEnable = 1; cycleLimit = 32'd4;
    for (int i = 0; i < 4; i++) begin
      set_pc(BASE + 32'(4 * i)); tick();
    end
    traceEnable = 0; rdReq = 1;
    tick(); tick();
    #2; resetN = 0; #1;
    n_vec++;
    if ({halted, haltCause, cycleCount, count, overflow, rdValid, rdPc, rdPcD, rdInstr, rdWe} !== '0) begin
      n_err++; $display("FAIL async_reset got h=%b cnt=%0d v=%b pc=%h exp all 0", halted, count, rdValid, rdPc);
    end
    idle_inputs(); model_reset();
    #1; resetN = 1;
    tick();
    n_vec++;
    if (halted !== 1'b0 || count !== 5'd0 || cycleCount !== 32'd1) begin
      n_err++; $display("FAIL async_release got h=%b cnt=%0d cyc=%0d exp 0 0 1", halted, count, cycleCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    bpAddr = 32'h20;
    for (int n = 0; n < 600; n++) begin
      set_pc(32'($urandom_range(0, 15) * 4));
      instruction    = $urandom;
      regWriteEnable = 1'($urandom_range(0, 1));
      traceEnable    = ($urandom_range(0, 3) != 0);
      bpEnable       = ($urandom_range(0, 7) == 0);
      cycleLimit     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 60)) : 32'd0;
      rdReq          = ($urandom_range(0, 1) == 1);
      resume         = ($urandom_range(0, 9) == 0);
      clearTrace     = ($urandom_range(0, 24) == 0);
      tick();
      n_vec++;
      if (halted !== m_halt || haltCause !== m_cause || cycleCount !== m_cyc ||
          count !== 5'(m_q.size()) || overflow !== m_ovf || rdValid !== m_rdv) begin
        n_err++; $display("FAIL rnd_ctrl@%0d got h=%b c=%b cyc=%0d cnt=%0d ovf=%b v=%b exp %b %b %0d %0d %b %b",
                          n, halted, haltCause, cycleCount, count, overflow, rdValid,
                          m_halt, m_cause, m_cyc, m_q.size(), m_ovf, m_rdv);
      end
      n_vec++;
      if ({rdPc, rdPcD, rdInstr, rdWe} !== m_rd) begin
        n_err++; $display("FAIL rnd_data@%0d got %h %h %h %b exp %h %h %h %b", n, rdPc, rdPcD, rdInstr, rdWe,
                          m_rd.pc, m_rd.pcd, m_rd.ins, m_rd.we);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cycle_limit();
    test_breakpoint();
    test_both_causes();
    test_drain_resume();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
